// File: rtl/cpu_step_ctrl_pkg.sv
// cpu_step_ctrl_pkg: shared FSM encoding and helpers
// for the single-cycle datapath step sequencer.
package cpu_step_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_BREAK  = 2'd3
  } state_t;

  // Stop condition sampled on the last settle cycle.
  function automatic logic stop_hit(
    input logic       b_en,
    input logic [7:0] b_addr,
    input logic [7:0] p,
    input logic       h
  );
    return (b_en && (p == b_addr)) || h;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stable-sample
// filter and one-cycle press pulse on 1->0.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level after a full run of equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      lvl   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        lvl   <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: clock-enable sequencer for the datapath
// with single step, free run and breakpoint/halt stop.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int RUN_DIV      = 50000000,
  parameter int SETTLE_CYC   = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_key_n,
  input  logic               run_sw,
  input  logic               bp_en,
  input  logic [7:0]         bp_addr,
  input  logic [7:0]         pc,
  input  logic               inst_halt,
  output logic               cpu_en,
  output logic [STATE_W-1:0] state,
  output logic               brk,
  output logic [CNT_W-1:0]   instr_cnt
);

  localparam int DW = $clog2(RUN_DIV);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  state_t        st;
  logic          press;
  logic          r1;
  logic          run_s;
  logic [DW-1:0] div;
  logic [SW-1:0] scnt;
  logic          origin_run;
  logic          check_en;
  logic          go;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key (
    .clk  (clk),
    .rst  (rst),
    .key_n(step_key_n),
    .press(press)
  );

  // Run switch only needs metastability protection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1    <= 1'b0;
      run_s <= 1'b0;
    end else begin
      r1    <= run_sw;
      run_s <= r1;
    end
  end

  // Decide whether this cycle issues a datapath strobe.
  always_comb begin
    go = 1'b0;
    unique case (st)
      ST_HALT:  go = press;
      ST_RUN:   go = run_s && (div == DIV_LAST);
      ST_BREAK: go = press;
      default:  go = 1'b0;
    endcase
  end

  // Main sequencer: strobe, settle, then run/halt/break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_HALT;
      cpu_en     <= 1'b0;
      brk        <= 1'b0;
      instr_cnt  <= '0;
      div        <= '0;
      scnt       <= '0;
      origin_run <= 1'b0;
      check_en   <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      if (go) begin
        cpu_en     <= 1'b1;
        instr_cnt  <= instr_cnt + 1'b1;
        div        <= '0;
        scnt       <= '0;
        brk        <= 1'b0;
        origin_run <= (st == ST_RUN) || ((st == ST_BREAK) && run_s);
        check_en   <= (st != ST_BREAK);
        st         <= ST_SETTLE;
      end else begin
        unique case (st)
          ST_HALT: begin
            if (run_s) begin
              st  <= ST_RUN;
              div <= '0;
            end
          end
          ST_RUN: begin
            if (!run_s) st <= ST_HALT;
            else        div <= div + 1'b1;
          end
          ST_SETTLE: begin
            div <= div + 1'b1;
            if (scnt == SET_LAST) begin
              scnt <= '0;
              if (check_en &&
                  stop_hit(bp_en, bp_addr, pc, inst_halt)) begin
                st  <= ST_BREAK;
                brk <= 1'b1;
              end else if (origin_run && run_s) begin
                st <= ST_RUN;
              end else begin
                st <= ST_HALT;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          ST_BREAK: st <= ST_BREAK;
          default:  st <= ST_HALT;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed stimulus with a deadline-based
// reference model checked every cycle.
module tb_cpu_step_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;
  localparam int SET = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          step_key_n = 1'b1;
  logic          run_sw = 1'b0;
  logic          bp_en = 1'b0;
  logic [7:0]    bp_addr = 8'd0;
  logic [7:0]    pc;
  logic          inst_halt;
  logic          cpu_en;
  logic [1:0]    state;
  logic          brk;
  logic [CW-1:0] instr_cnt;
  logic          halt_mode = 1'b0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .RUN_DIV     (DIV),
    .SETTLE_CYC  (SET),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_key_n(step_key_n),
    .run_sw    (run_sw),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .inst_halt (inst_halt),
    .cpu_en    (cpu_en),
    .state     (state),
    .brk       (brk),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Toy datapath PC advancing on the enable strobe.
  always @(posedge clk or posedge rst) begin
    if (rst)         pc <= 8'd0;
    else if (cpu_en) pc <= pc + 8'd1;
  end

  assign inst_halt = halt_mode && (pc == 8'd5);

  int vecs = 0;
  int errs = 0;
  int shown = 0;
  int cyc = 0;
  int en_count = 0;
  int last_en = -1;
  int en_q[$];

  // Reference model: mode plus absolute-cycle deadlines.
  int mst;
  int m_set_end;
  int m_next_run;
  bit m_orun, m_chk, m_en, m_press, m_acc;
  int m_cnt;
  bit kh0, kh1, rh0, rh1;
  bit dh[$];

  task automatic m_reset();
    mst = 0; m_en = 0; m_cnt = 0; m_press = 0; m_acc = 1;
    m_orun = 0; m_chk = 0; m_set_end = 0; m_next_run = 0;
    kh0 = 1; kh1 = 1; rh0 = 0; rh1 = 0;
    dh.delete();
  endtask

  task automatic m_strobe(input bit orun, input bit chk, input int n);
    m_en = 1;
    m_cnt = (m_cnt + 1) % (1 << CW);
    mst = 2;
    m_set_end = n + SET;
    m_next_run = n + DIV;
    m_orun = orun;
    m_chk = chk;
  endtask

  task automatic m_step(input bit key, input bit run,
                        input logic [7:0] p, input bit bpe,
                        input logic [7:0] bpa, input bit hl,
                        input int n);
    bit syn, rs, pin, all;
    syn = kh1; kh1 = kh0; kh0 = key;
    rs  = rh1; rh1 = rh0; rh0 = run;
    pin = m_press;
    m_press = 0;
    dh.push_back(syn);
    if (dh.size() > DEB) void'(dh.pop_front());
    if (dh.size() == DEB) begin
      all = 1;
      foreach (dh[i]) if (dh[i] == m_acc) all = 0;
      if (all) begin
        m_acc = !m_acc;
        m_press = !m_acc;
      end
    end
    m_en = 0;
    case (mst)
      0: begin
        if (pin) m_strobe(0, 1, n);
        else if (rs) begin mst = 1; m_next_run = n + DIV; end
      end
      1: begin
        if (!rs) mst = 0;
        else if (n == m_next_run) m_strobe(1, 1, n);
      end
      2: begin
        if (n == m_set_end) begin
          if (m_chk && ((bpe && p == bpa) || hl)) mst = 3;
          else if (m_orun && rs) mst = 1;
          else mst = 0;
        end
      end
      default: begin
        if (pin) m_strobe(rs, 0, n);
      end
    endcase
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) m_reset();
      else m_step(step_key_n, run_sw, pc, bp_en, bp_addr, inst_halt, cyc);
      @(negedge clk);
      if (rst) m_reset();
      vecs++;
      if (cpu_en !== m_en || state !== 2'(mst) ||
          brk !== (mst == 3) || instr_cnt !== CW'(m_cnt)) begin
        errs++;
        if (shown < 20)
          $display("FAIL model cyc%0d: en=%b st=%0d brk=%b cnt=%0d want en=%b st=%0d brk=%b cnt=%0d",
                   cyc, cpu_en, state, brk, instr_cnt,
                   m_en, mst, (mst == 3), m_cnt % (1 << CW));
        shown++;
      end
      if (cpu_en === 1'b1) begin
        en_count++;
        last_en = cyc;
        en_q.push_back(cyc);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_key(input int low, input int high);
    step_key_n = 1'b0;
    tick(low);
    step_key_n = 1'b1;
    tick(high);
  endtask

  int c0, e0, n;
  int q[$];

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("reset_state", int'(state), 0);
    chk("reset_brk", int'(brk), 0);
    chk("reset_cnt", int'(instr_cnt), 0);
    chk("reset_en", int'(cpu_en), 0);

    // single step
    c0 = cyc; e0 = en_count;
    press_key(12, 10);
    chk("step_count", en_count - e0, 1);
    chk("step_latency", last_en - c0, 7);
    chk("step_pc", int'(pc), 1);
    chk("step_state", int'(state), 0);

    // short glitch
    e0 = en_count;
    press_key(2, 12);
    chk("glitch_count", en_count - e0, 0);

    // free run with a press in the middle
    e0 = en_count;
    en_q.delete();
    run_sw = 1'b1;
    tick(30);
    press_key(12, 22);
    run_sw = 1'b0;
    tick(6);
    n = en_count - e0;
    q = en_q;
    chk("run_count", int'(n == 7 || n == 8), 1);
    for (int i = 1; i < q.size(); i++)
      chk("run_gap", q[i] - q[i-1], 8);
    chk("run_state", int'(state), 0);

    // asynchronous reset mid-run
    run_sw = 1'b1;
    tick(20);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_en", int'(cpu_en), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_cnt", int'(instr_cnt), 0);
    run_sw = 1'b0;
    tick(2);
    #1;
    rst = 1'b0;
    e0 = en_count;
    tick(10);
    chk("arst_quiet", en_count - e0, 0);
    chk("arst_pc", int'(pc), 0);

    // breakpoint at pc 3
    bp_en = 1'b1;
    bp_addr = 8'd3;
    run_sw = 1'b1;
    tick(40);
    chk("bp_state", int'(state), 3);
    chk("bp_brk", int'(brk), 1);
    chk("bp_pc", int'(pc), 3);
    e0 = en_count;
    tick(40);
    chk("bp_quiet", en_count - e0, 0);
    e0 = en_count;
    step_key_n = 1'b0;
    tick(12);
    step_key_n = 1'b1;
    chk("bp_step_count", en_count - e0, 1);
    chk("bp_step_pc", int'(pc), 4);
    chk("bp_resume_state", int'(state), 1);
    chk("bp_resume_brk", int'(brk), 0);
    run_sw = 1'b0;
    bp_en = 1'b0;
    tick(10);

    // halt instruction at pc 5
    halt_mode = 1'b1;
    run_sw = 1'b1;
    tick(20);
    chk("halt_state", int'(state), 3);
    chk("halt_brk", int'(brk), 1);
    chk("halt_pc", int'(pc), 5);
    run_sw = 1'b0;
    tick(4);
    e0 = en_count;
    press_key(12, 2);
    chk("halt_step_count", en_count - e0, 1);
    chk("halt_step_state", int'(state), 0);
    chk("halt_step_brk", int'(brk), 0);
    chk("halt_step_pc", int'(pc), 6);
    halt_mode = 1'b0;
    tick(8);

    // counter wrap after 16 steps
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    e0 = en_count;
    repeat (16) press_key(8, 8);
    chk("wrap_count", en_count - e0, 16);
    chk("wrap_cnt", int'(instr_cnt), 0);
    chk("wrap_pc", int'(pc), 16);
    chk("wrap_state", int'(state), 0);
    chk("wrap_brk", int'(brk), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
